// File: rtl/sisc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sisc_mem_arbiter
//
// Sequencer and arbiter for the SISC's single-ported memory. Two requesters
// share it: the instruction-fetch port (read-only) and the data port
// (LOD/STR). One transaction is in flight at a time. When both ports request
// in the same IDLE cycle, the port that was not granted last wins
// (round-robin). Read data comes back in a per-port holding register together
// with a one-cycle valid pulse. A data write is acknowledged with a dm_valid
// pulse and leaves dm_rdata unchanged.
//
// FSM: IDLE -> ISSUE -> (WAIT ->) RESP -> IDLE for reads,
//      IDLE -> ISSUE -> IDLE for writes.
//
// Parameters
//   AW      address width
//   DW      data width
//   RD_LAT  memory read latency, mem_en cycle to valid mem_rdata (1..4)
//
// Ports
//   clk, rst_f                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch read request (held until if_gnt)
//   if_gnt                     pulse: fetch request issued to memory
//   if_rdata/if_valid          fetch read data, pulse when it is updated
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_gnt)
//   dm_gnt                     pulse: data request issued to memory
//   dm_rdata/dm_valid          load data, pulse on load data or write ack
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write strobe, addr, data
//   mem_rdata                  memory read data
//   busy                       high whenever the FSM is not in IDLE
//
// Every output is either a register or a decode of registered state, so
// there is no combinational path from a request input to any output.
// -----------------------------------------------------------------------------
module sisc_mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_f,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // WAIT lasts RD_LAT-1 cycles: the counter is loaded with RD_LAT-2 in ISSUE
    // and WAIT exits when it reads zero. For RD_LAT <= 2 the load value is 0
    // (and for RD_LAT = 1 WAIT is skipped altogether).
    localparam logic [1:0] WAIT_LOAD = (RD_LAT > 2) ? 2'(RD_LAT - 2) : 2'd0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    wait_cnt;
    logic          owner;        // port that owns the current transaction
    logic          last_owner;   // port granted most recently (round-robin)
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          if_valid_q;
    logic          dm_valid_q;

    // -------------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE, where requests are sampled.
    // -------------------------------------------------------------------------
    logic any_req;
    logic pick_data;

    assign any_req = if_req | dm_req;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        pick_data = OWN_FETCH;
        if (dm_req && !if_req) begin
            pick_data = OWN_DATA;
        end else if (dm_req && if_req) begin
            // Tie: the port not granted last wins.
            pick_data = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_nxt = S_IDLE;
                end else if (RD_LAT > 1) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT down-counter.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wait_cnt <= 2'd0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == S_WAIT && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch: captured on the IDLE edge that accepts a request and held
    // for the rest of the transaction, so requesters may drop or change their
    // inputs once granted. The fetch port never writes, so we_q is only set
    // for data-port writes. Write data is only captured for the data port.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            owner   <= OWN_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == S_IDLE && any_req) begin
            owner <= pick_data;
            if (pick_data == OWN_DATA) begin
                we_q    <= dm_we;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= if_addr;
            end
        end
    end

    // Round-robin history. Reset to DATA so that fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            last_owner <= OWN_DATA;
        end else if (state == S_ISSUE) begin
            last_owner <= owner;
        end
    end

    // -------------------------------------------------------------------------
    // Response path. Read data is captured at the end of RESP, and the valid
    // pulse appears in the following cycle (which is already IDLE). A write is
    // acknowledged in the cycle after its ISSUE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            if_valid_q <= (state == S_RESP) && (owner == OWN_FETCH);
            dm_valid_q <= (owner == OWN_DATA) &&
                          ((state == S_RESP) || (state == S_ISSUE && we_q));
            if (state == S_RESP) begin
                if (owner == OWN_FETCH) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decodes of registered state, or registers directly.
    // -------------------------------------------------------------------------
    logic issue;
    assign issue = (state == S_ISSUE);

    assign busy      = (state != S_IDLE);
    assign mem_en    = issue;
    assign mem_we    = issue & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = issue & (owner == OWN_FETCH);
    assign dm_gnt    = issue & (owner == OWN_DATA);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sisc_mem_arbiter
//
// Two arbiter instances: dut_a with RD_LAT = 1, driven from a cycle-by-cycle
// vector table (reset, fetch read, store, load, contention), and dut_b with
// RD_LAT = 3, driven by hand-written sequences (long-latency load, request
// arriving mid-transaction, reset in WAIT, reset tie rule, store/readback).
// Each instance talks to a small memory model with the matching latency.
// Control outputs are compared as a 7-bit vector:
//   {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, busy}
// -----------------------------------------------------------------------------
module tb_sisc_mem_arbiter;

    localparam logic [6:0] C_NONE    = 7'b0000000;
    localparam logic [6:0] C_BUSY    = 7'b0000001;
    localparam logic [6:0] C_IGNT    = 7'b1000101;
    localparam logic [6:0] C_DGNT_RD = 7'b0100101;
    localparam logic [6:0] C_DGNT_WR = 7'b0100111;
    localparam logic [6:0] C_IVAL    = 7'b0010000;
    localparam logic [6:0] C_DVAL    = 7'b0001000;

    localparam logic [31:0] W_ST   = 32'h1234_5678;
    localparam logic [31:0] D_BEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] D_CAFE = 32'hCAFE_F00D;
    localparam logic [31:0] D_A5   = 32'hA5A5_0002;
    localparam logic [31:0] W_55   = 32'h55AA_55AA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------------------------------------------------------- dut_a
    logic        a_rst_f, a_if_req, a_dm_req, a_dm_we;
    logic [15:0] a_if_addr, a_dm_addr, a_mem_addr;
    logic [31:0] a_dm_wdata, a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_if_gnt, a_if_valid, a_dm_gnt, a_dm_valid, a_mem_en, a_mem_we, a_busy;
    logic [6:0]  a_ctl;
    assign a_ctl = {a_if_gnt, a_dm_gnt, a_if_valid, a_dm_valid, a_mem_en, a_mem_we, a_busy};

    sisc_mem_arbiter #(.AW(16), .DW(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_f(a_rst_f),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rdata(a_dm_rdata), .dm_valid(a_dm_valid),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    // ---------------------------------------------------------------- dut_b
    logic        b_rst_f, b_if_req, b_dm_req, b_dm_we;
    logic [15:0] b_if_addr, b_dm_addr, b_mem_addr;
    logic [31:0] b_dm_wdata, b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid, b_mem_en, b_mem_we, b_busy;
    logic [6:0]  b_ctl;
    assign b_ctl = {b_if_gnt, b_dm_gnt, b_if_valid, b_dm_valid, b_mem_en, b_mem_we, b_busy};

    sisc_mem_arbiter #(.AW(16), .DW(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_f(b_rst_f),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // -------------------------------------------------------- memory models
    // Read data is presented only in the cycle exactly RD_LAT after mem_en
    // (zero otherwise), so a mistimed capture picks up the wrong value.
    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            'h02:    return D_A5;
            'h10:    return D_BEEF;
            'h20:    return D_CAFE;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        a_loaded = 1'b0;
    logic        b_loaded = 1'b0;
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];

    always @(posedge clk) begin
        if (!a_loaded) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
            a_pipe   <= 32'h0;
            a_loaded <= 1'b1;
        end else begin
            a_pipe <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:0]] : 32'h0;
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        end
    end
    assign a_mem_rdata = a_pipe;

    always @(posedge clk) begin
        if (!b_loaded) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
            for (int j = 0; j < 3; j++) b_pipe[j] <= 32'h0;
            b_loaded <= 1'b1;
        end else begin
            b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : 32'h0;
            b_pipe[1] <= b_pipe[0];
            b_pipe[2] <= b_pipe[1];
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        end
    end
    assign b_mem_rdata = b_pipe[2];

    // --------------------------------------------------------------- checks
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick_b(input logic [6:0] exp, input string nm);
        @(posedge clk);
        #1;
        check(nm, 32'(b_ctl), 32'(exp));
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic        rst_f;
        logic        if_req;
        logic [15:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [15:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [6:0]  ctl;
        logic [15:0] addr;
        logic        wd_chk;
        logic [31:0] wdata;
        logic [31:0] if_rdata;
        logic [31:0] dm_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rst, input int ir, input logic [31:0] ia,
                                input int dr, input int dw, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [6:0] ctl,
                                input logic [31:0] addr, input int wdc,
                                input logic [31:0] wd, input logic [31:0] ird,
                                input logic [31:0] drd);
        vec_t v;
        v.rst_f    = (rst != 0);
        v.if_req   = (ir != 0);
        v.if_addr  = 16'(ia);
        v.dm_req   = (dr != 0);
        v.dm_we    = (dw != 0);
        v.dm_addr  = 16'(da);
        v.dm_wdata = dwd;
        v.ctl      = ctl;
        v.addr     = 16'(addr);
        v.wd_chk   = (wdc != 0);
        v.wdata    = wd;
        v.if_rdata = ird;
        v.dm_rdata = drd;
        return v;
    endfunction

    initial begin
        // Inputs of each row are applied before a clock edge; expected values
        // describe the cycle that follows that edge.
        //              rst ir ia    dr dw da    dwd   ctl        addr wdc wd    ird     drd
        // Reset held with both requests high.
        vecs.push_back(mk(0, 1, 'h10, 1, 1, 'h40, W_ST, C_NONE,    'h00, 1, 0,    0,      0));
        vecs.push_back(mk(0, 1, 'h10, 1, 1, 'h40, W_ST, C_NONE,    'h00, 1, 0,    0,      0));
        vecs.push_back(mk(0, 1, 'h10, 1, 1, 'h40, W_ST, C_NONE,    'h00, 1, 0,    0,      0));
        // Release: fetch wins the first tie; fetch read of 0x0010.
        vecs.push_back(mk(1, 1, 'h10, 1, 1, 'h40, W_ST, C_IGNT,    'h10, 0, 0,    0,      0));
        vecs.push_back(mk(1, 0, 'h10, 1, 1, 'h40, W_ST, C_BUSY,    'h10, 0, 0,    0,      0));
        vecs.push_back(mk(1, 0, 'h10, 1, 1, 'h40, W_ST, C_IVAL,    'h10, 0, 0,    D_BEEF, 0));
        // Pending store to 0x0040 issued from IDLE, acked next cycle.
        vecs.push_back(mk(1, 0, 'h10, 1, 1, 'h40, W_ST, C_DGNT_WR, 'h40, 1, W_ST, D_BEEF, 0));
        vecs.push_back(mk(1, 0, 'h10, 0, 1, 'h40, W_ST, C_DVAL,    'h40, 1, W_ST, D_BEEF, 0));
        // Fetch of 0x0040 returns the stored word.
        vecs.push_back(mk(1, 1, 'h40, 0, 0, 'h40, 0,    C_IGNT,    'h40, 0, 0,    D_BEEF, 0));
        vecs.push_back(mk(1, 0, 'h40, 0, 0, 'h40, 0,    C_BUSY,    'h40, 0, 0,    D_BEEF, 0));
        vecs.push_back(mk(1, 0, 'h40, 0, 0, 'h40, 0,    C_IVAL,    'h40, 0, 0,    W_ST,   0));
        // Load from 0x0010.
        vecs.push_back(mk(1, 0, 'h40, 1, 0, 'h10, 0,    C_DGNT_RD, 'h10, 0, 0,    W_ST,   0));
        vecs.push_back(mk(1, 0, 'h40, 0, 0, 'h10, 0,    C_BUSY,    'h10, 0, 0,    W_ST,   0));
        vecs.push_back(mk(1, 0, 'h40, 0, 0, 'h10, 0,    C_DVAL,    'h10, 0, 0,    W_ST,   D_BEEF));
        // Contention: both held, grants alternate IF, DM, IF at 3-cycle spacing.
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_IGNT,    'h20, 0, 0,    W_ST,   D_BEEF));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_BUSY,    'h20, 0, 0,    W_ST,   D_BEEF));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_IVAL,    'h20, 0, 0,    D_CAFE, D_BEEF));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_DGNT_RD, 'h40, 0, 0,    D_CAFE, D_BEEF));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_BUSY,    'h40, 0, 0,    D_CAFE, D_BEEF));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_DVAL,    'h40, 0, 0,    D_CAFE, W_ST));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 'h40, 0,    C_IGNT,    'h20, 0, 0,    D_CAFE, W_ST));
        vecs.push_back(mk(1, 0, 'h20, 0, 0, 'h40, 0,    C_BUSY,    'h20, 0, 0,    D_CAFE, W_ST));
        vecs.push_back(mk(1, 0, 'h20, 0, 0, 'h40, 0,    C_IVAL,    'h20, 0, 0,    D_CAFE, W_ST));
        vecs.push_back(mk(1, 0, 'h20, 0, 0, 'h40, 0,    C_NONE,    'h20, 0, 0,    D_CAFE, W_ST));

        // dut_b held in reset with idle inputs while dut_a runs.
        b_rst_f = 1'b0; b_if_req = 1'b0; b_if_addr = '0;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;

        // ------------------------------------------------ table on dut_a
        for (int k = 0; k < vecs.size(); k++) begin
            a_rst_f    = vecs[k].rst_f;
            a_if_req   = vecs[k].if_req;
            a_if_addr  = vecs[k].if_addr;
            a_dm_req   = vecs[k].dm_req;
            a_dm_we    = vecs[k].dm_we;
            a_dm_addr  = vecs[k].dm_addr;
            a_dm_wdata = vecs[k].dm_wdata;
            @(posedge clk);
            #1;
            check($sformatf("v%0d ctl", k), 32'(a_ctl), 32'(vecs[k].ctl));
            check($sformatf("v%0d mem_addr", k), 32'(a_mem_addr), 32'(vecs[k].addr));
            if (vecs[k].wd_chk) check($sformatf("v%0d mem_wdata", k), a_mem_wdata, vecs[k].wdata);
            check($sformatf("v%0d if_rdata", k), a_if_rdata, vecs[k].if_rdata);
            check($sformatf("v%0d dm_rdata", k), a_dm_rdata, vecs[k].dm_rdata);
        end

        // ------------------------------------------------ dut_b, RD_LAT = 3
        check("b reset ctl", 32'(b_ctl), 32'(C_NONE));
        check("b reset mem_addr", 32'(b_mem_addr), 32'h0);
        check("b reset mem_wdata", b_mem_wdata, 32'h0);
        b_rst_f = 1'b1;
        tick_b(C_NONE, "b idle");

        // LOD from 0x0002; a fetch request shows up mid-transaction.
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 16'h0002;
        tick_b(C_DGNT_RD, "b lod gnt");
        check("b lod mem_addr", 32'(b_mem_addr), 32'h2);
        b_dm_req = 1'b0; b_if_req = 1'b1; b_if_addr = 16'h0020;
        tick_b(C_BUSY, "b lod wait1");
        tick_b(C_BUSY, "b lod wait2");
        tick_b(C_BUSY, "b lod resp");
        tick_b(C_DVAL, "b lod valid");
        check("b lod dm_rdata", b_dm_rdata, D_A5);
        tick_b(C_IGNT, "b late fetch gnt");
        check("b late fetch addr", 32'(b_mem_addr), 32'h20);
        b_if_req = 1'b0;
        tick_b(C_BUSY, "b fetch wait1");

        // Reset in WAIT: outputs clear at once, no valid afterwards.
        b_rst_f = 1'b0;
        #1;
        check("b async reset ctl", 32'(b_ctl), 32'(C_NONE));
        check("b async reset dm_rdata", b_dm_rdata, 32'h0);
        tick_b(C_NONE, "b in reset 1");
        tick_b(C_NONE, "b in reset 2");
        b_rst_f = 1'b1;
        for (int k = 0; k < 6; k++) tick_b(C_NONE, $sformatf("b no stray valid %0d", k));
        check("b if_rdata after abort", b_if_rdata, 32'h0);

        // Tie after reset goes to fetch even though fetch was granted last.
        b_if_req = 1'b1; b_if_addr = 16'h0002;
        b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 16'h0030; b_dm_wdata = W_55;
        tick_b(C_IGNT, "b tie after reset");
        check("b tie addr", 32'(b_mem_addr), 32'h2);
        b_if_req = 1'b0;
        tick_b(C_BUSY, "b tie wait1");
        tick_b(C_BUSY, "b tie wait2");
        tick_b(C_BUSY, "b tie resp");
        tick_b(C_IVAL, "b tie valid");
        check("b tie if_rdata", b_if_rdata, D_A5);
        tick_b(C_DGNT_WR, "b str gnt");
        check("b str addr", 32'(b_mem_addr), 32'h30);
        check("b str wdata", b_mem_wdata, W_55);
        b_dm_req = 1'b0;
        tick_b(C_DVAL, "b str ack");
        check("b str dm_rdata kept", b_dm_rdata, 32'h0);

        // Read back the stored word.
        b_dm_req = 1'b1; b_dm_we = 1'b0;
        tick_b(C_DGNT_RD, "b rb gnt");
        b_dm_req = 1'b0;
        tick_b(C_BUSY, "b rb wait1");
        tick_b(C_BUSY, "b rb wait2");
        tick_b(C_BUSY, "b rb resp");
        tick_b(C_DVAL, "b rb valid");
        check("b rb dm_rdata", b_dm_rdata, W_55);
        tick_b(C_NONE, "b final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sisc_mem_arbiter.md
# sisc_mem_arbiter

Sequencer and arbiter for the SISC's single-ported memory, shared between the instruction-fetch port (driven by the PC/IR path during fetch) and the data port (driven by LOD/STR in the mem state). It accepts one request at a time and arbitrates round-robin when both ports request together. It drives the memory enable, write-enable, address and write-data lines, and returns read data with a one-cycle valid pulse. `busy` tells the control FSM that a transaction is in flight so it can stall.

## Interface
- `AW`, 16: address width.
- `DW`, 32: data width.
- `RD_LAT`, 1: memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range 1..4.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_f`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  AW  fetch address; stable while `if_req` is high.
- `if_gnt`  out  1  one-cycle pulse: fetch request issued to memory.
- `if_rdata`  out  DW  fetch read data; holds its value until the next fetch response.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` updated.
- `dm_req`  in  1  data request; held until `dm_gnt`.
- `dm_we`  in  1  1 = write (STR), 0 = read (LOD); stable with `dm_req`.
- `dm_addr`  in  AW  data address.
- `dm_wdata`  in  DW  store data.
- `dm_gnt`  out  1  one-cycle pulse: data request issued.
- `dm_rdata`  out  DW  load data; holds its value until the next data read response.
- `dm_valid`  out  1  one-cycle pulse: read data ready, or write acknowledged.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe; only ever high together with `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - No requests: remain in IDLE.
  - Exactly one request: grant that port and go to ISSUE.
  - Both requesting: grant the port not granted last (`last_owner` register), then go to ISSUE.
  - `owner`, `addr`, `we` and `wdata` are latched on this edge.
- **ISSUE:**
  - Outputs: `mem_en` = 1, `mem_we` = latched `we`, `mem_addr`/`mem_wdata` from the latch, and the owner's `gnt` = 1.
  - `last_owner` is updated to `owner`.
  - Write: go to IDLE and pulse `dm_valid` in the next cycle.
  - Read: go to WAIT if `RD_LAT` > 1, else to RESP.
- **WAIT:** a down-counter loaded with `RD_LAT`-2 in ISSUE; move to RESP when it reaches 0. `mem_en` = 0.
- **RESP:** `mem_rdata` is sampled into the owner's `rdata` register at the end of the cycle; go to IDLE. The owner's `valid` pulses in the following cycle.
- **Requests:** requests are not re-sampled outside IDLE. A request arriving mid-transaction waits.
- **Port behaviour after grant:** a requester drops `req` in the cycle after `gnt` or keeps it high for a new access. A still-high `req` in IDLE is treated as a new request.
- **`mem_we`:** asserted for data writes only. The fetch port never writes.
- **Reset values:**
  - State = IDLE and counter = 0.
  - Outputs: `busy`, `if_gnt`, `dm_gnt`, `if_valid`, `dm_valid`, `mem_en` and `mem_we` all 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` all 0.
  - `last_owner` = DATA, so fetch wins the first tie.
- **Reset mid-transaction:** the transaction is aborted immediately. No `valid` pulse, no `gnt` and no memory strobe occur after `rst_f` falls. The first grant after release follows the reset tie rule.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any `req` input to any output.
- **Read** (request seen at edge N):
  - ISSUE in cycle N+1 (`gnt`, `mem_en`).
  - RESP in cycle N+1+`RD_LAT`.
  - `valid` in cycle N+2+`RD_LAT`.
  - `RD_LAT` = 1 gives `valid` 3 cycles after the request edge.
- **Write** (request seen at edge N): ISSUE in cycle N+1, `dm_valid` in cycle N+2.
- **Back-to-back throughput:** one read per `RD_LAT`+2 cycles; one write per 2 cycles. The `valid` cycle overlaps the next IDLE.
- **`busy`:** high from ISSUE through RESP inclusive; low in IDLE, including the `valid` cycle.

## Test plan
- **Reset:** hold `rst_f`=0 for 3 cycles with both reqs high → all outputs 0. Release → first grant goes to fetch: `if_gnt` at cycle 1, `mem_en`=1, `mem_addr`=`if_addr`.
- **Fetch read, `RD_LAT`=1:** `if_req` with `if_addr`=0x0010, memory returns 0xDEADBEEF → `if_gnt` at N+1, `if_valid` at N+3 with `if_rdata`=0xDEADBEEF, `busy` high for 2 cycles.
- **Store:** `dm_req`, `dm_we`=1, `dm_addr`=0x0040, `dm_wdata`=0x12345678 → exactly one cycle with `mem_en`=`mem_we`=1 at that address/data, `dm_valid` at N+2, `dm_rdata` unchanged.
- **Contention:** `if_req` and `dm_req` held continuously with `RD_LAT`=1 → grants alternate IF, DM, IF, DM at 3-cycle spacing; `mem_we` never high on a fetch grant.
- **`RD_LAT`=3:** LOD from 0x0002 → `mem_en` a single cycle, RESP 3 cycles later, `dm_valid` at N+5; a mid-transaction `if_req` is granted only after return to IDLE.
- **Reset mid-read:** drop `rst_f` during WAIT → no `valid` pulse is ever produced; the FSM is in IDLE and, after release, a new `dm_req` completes normally.
